// File: rtl/instr_fetch_queue.sv
// Fetch PC owner: one outstanding req/ack read at a time, DEPTH-entry prefetch buffer to decode.
// First instruction valid 2 edges after reset; 1 word/cycle; fetch pauses while the buffer is full.
module instr_fetch_queue #(
  parameter int             W        = 32,
  parameter int             DEPTH    = 4,
  parameter logic [W-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  output logic         mem_req,
  output logic [W-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata,
  input  logic         redirect,
  input  logic [W-1:0] redirect_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [W-1:0] instr,
  output logic [W-1:0] instr_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] dat;
  } entry_t;

  state_t        state, state_nxt;
  logic [W-1:0]  fetch_pc, fetch_pc_nxt;
  entry_t        buf_q [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop;

  // Redirect wins over both queue ports in the same cycle.
  assign push = (state == REQ) && mem_ack && !redirect;
  assign pop  = instr_valid && instr_ready && !redirect;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc;
        end else if (count < FULL) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc;
          state_nxt    = mem_ack ? IDLE : DROP;
        end else if (mem_ack) begin
          fetch_pc_nxt = fetch_pc + W'(1);
          state_nxt    = (count_nxt < FULL) ? REQ : IDLE;
        end
      end
      DROP: begin
        // The in-flight read still has to complete; its data is thrown away.
        if (redirect) begin
          fetch_pc_nxt = redirect_pc;
        end
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) begin
      buf_q[wr_ptr] <= '{pc: fetch_pc, dat: mem_rdata};
    end
  end

  assign mem_req     = (state == REQ) || (state == DROP);
  assign mem_addr    = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? buf_q[rd_ptr].dat : '0;
  assign instr_pc    = instr_valid ? buf_q[rd_ptr].pc  : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table, hand corner sequences, randomized run vs queue model.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  instr_fetch_queue #(.W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: prefetch contents as a queue, plus request-in-flight and discard flags.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        mq[$];
  logic        m_out   = 1'b0;
  logic        m_stale = 1'b0;
  logic [31:0] m_pc    = 32'h0;

  task automatic model_step(input logic r, input logic a, input logic [31:0] d,
                            input logic rdir, input logic [31:0] rpc, input logic rdy);
    int sz;
    if (!r) begin
      m_out = 1'b0; m_stale = 1'b0; m_pc = 32'h0; mq.delete();
      return;
    end
    if (rdir) begin
      mq.delete();
      m_pc = rpc;
      if (m_out) begin
        if (a) begin m_out = 1'b0; m_stale = 1'b0; end
        else m_stale = 1'b1;
      end
      return;
    end
    sz = mq.size();
    if (sz != 0 && rdy) void'(mq.pop_front());
    if (m_out && m_stale) begin
      if (a) begin m_out = 1'b0; m_stale = 1'b0; end
    end else if (m_out) begin
      if (a) begin
        mq.push_back('{pc: m_pc, word: d});
        m_pc  = m_pc + 32'd1;
        m_out = (mq.size() < DEPTH);
      end
    end else begin
      m_out = (sz < DEPTH);
    end
  endtask

  // Memory: acks after 'lat' waiting cycles; data is 0x1000+addr or random.
  int lat       = 0;
  int wait_cnt  = 0;
  bit rand_mode = 1'b0;

  task automatic cyc(input logic r, input logic rdy, input logic rdir, input logic [31:0] rpc);
    logic        a;
    logic [31:0] d;
    a = (mem_req === 1'b1) && (wait_cnt >= lat);
    d = rand_mode ? $urandom : 32'h1000 + mem_addr;
    rst = r; instr_ready = rdy; redirect = rdir; redirect_pc = rpc;
    mem_ack = a; mem_rdata = d;
    model_step(r, a, d, rdir, rpc, rdy);
    if (!r || a) begin
      wait_cnt = 0;
      if (a && rand_mode) lat = $urandom_range(0, 3);
    end else if (mem_req === 1'b1) begin
      wait_cnt++;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        r;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic rdy, input logic req, input logic [31:0] addr,
                     input logic vld, input logic [31:0] pc, input logic [31:0] ins);
    vec_t v;
    v.r = r; v.rdy = rdy; v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.ins = ins;
    tbl.push_back(v);
  endtask

  initial begin
    int          n;
    logic        r, rdy, rdir;
    logic [31:0] rpc, e_pc, e_ins;
    logic        e_vld;

    rst = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_ack = 1'b0; mem_rdata = '0;

    // Row = inputs for a cycle and the outputs expected during that cycle (zero-wait memory).
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0);
    add(1, 1, 1, 1, 1, 0, 32'h1000);
    add(1, 1, 1, 2, 1, 1, 32'h1001);
    add(1, 1, 1, 3, 1, 2, 32'h1002);
    add(0, 1, 1, 4, 1, 3, 32'h1003);   // reset while a request is being acked
    add(0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1, 0, 32'h1000);
    add(1, 0, 1, 2, 1, 0, 32'h1000);
    add(1, 0, 1, 3, 1, 0, 32'h1000);
    add(1, 0, 0, 4, 1, 0, 32'h1000);   // full: fetch paused
    add(1, 0, 0, 4, 1, 0, 32'h1000);
    add(1, 1, 0, 4, 1, 0, 32'h1000);
    add(1, 0, 0, 4, 1, 1, 32'h1001);
    add(1, 0, 1, 4, 1, 1, 32'h1001);
    add(1, 1, 0, 5, 1, 1, 32'h1001);
    add(1, 1, 0, 5, 1, 2, 32'h1002);
    add(1, 1, 1, 5, 1, 3, 32'h1003);   // push+pop with two entries held
    add(1, 1, 1, 6, 1, 4, 32'h1004);
    add(1, 1, 1, 7, 1, 5, 32'h1005);

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    foreach (tbl[i]) begin
      chk("tbl_req",   mem_req,     tbl[i].req);
      chk("tbl_addr",  mem_addr,    tbl[i].addr);
      chk("tbl_valid", instr_valid, tbl[i].vld);
      chk("tbl_pc",    instr_pc,    tbl[i].pc);
      chk("tbl_instr", instr,       tbl[i].ins);
      cyc(tbl[i].r, tbl[i].rdy, 1'b0, 32'h0);
    end

    // Slow memory: request held with a stable address until the ack.
    lat = 3;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk("slow_req_held", mem_req,     1'b1);
      chk("slow_addr",     mem_addr,    32'h0);
      chk("slow_no_data",  instr_valid, 1'b0);
      cyc(1, 0, 0, 0);
    end
    chk("slow_valid", instr_valid, 1'b1);
    chk("slow_pc",    instr_pc,    32'h0);
    chk("slow_instr", instr,       32'h1000);
    chk("slow_next",  mem_addr,    32'h1);

    // Redirect on an acked cycle with three entries held, pop request ignored.
    lat = 0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("redir_pre_pc",  instr_pc, 32'h0);
    chk("redir_pre_req", mem_req,  1'b1);
    cyc(1, 1, 1, 32'h40);
    chk("redir_flush", instr_valid, 1'b0);
    chk("redir_idle",  mem_req,     1'b0);
    chk("redir_addr",  mem_addr,    32'h40);
    cyc(1, 1, 0, 0);
    chk("redir_req",  mem_req,  1'b1);
    chk("redir_addr2", mem_addr, 32'h40);
    cyc(1, 1, 0, 0);
    chk("redir_head_pc", instr_pc, 32'h40);
    chk("redir_head",    instr,    32'h1040);

    // Redirect while a request is pending: stale read completes and is discarded.
    lat = 2;
    instr_ready = 1'b0;
    cyc(1, 0, 1, 32'h80);
    chk("drop_req",   mem_req,     1'b1);
    chk("drop_valid", instr_valid, 1'b0);
    chk("drop_addr",  mem_addr,    32'h80);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("drop_done_req",   mem_req,     1'b0);
    chk("drop_discarded",  instr_valid, 1'b0);
    cyc(1, 0, 0, 0);
    chk("drop_refetch_req",  mem_req,  1'b1);
    chk("drop_refetch_addr", mem_addr, 32'h80);
    n = 0;
    while (instr_valid !== 1'b1 && n < 10) begin
      cyc(1, 0, 0, 0);
      n++;
    end
    chk("drop_first_valid", instr_valid, 1'b1);
    chk("drop_first_pc",    instr_pc,    32'h80);
    chk("drop_first_instr", instr,       32'h1080);

    // Randomized traffic against the reference model.
    rand_mode = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      e_vld = (mq.size() != 0);
      e_pc  = e_vld ? mq[0].pc   : 32'h0;
      e_ins = e_vld ? mq[0].word : 32'h0;
      chk("rnd_req",   mem_req,     m_out);
      chk("rnd_addr",  mem_addr,    m_pc);
      chk("rnd_valid", instr_valid, e_vld);
      chk("rnd_pc",    instr_pc,    e_pc);
      chk("rnd_instr", instr,       e_ins);
      r    = ($urandom_range(0, 299) != 0);
      rdy  = ($urandom_range(0, 3) != 0);
      rdir = ($urandom_range(0, 15) == 0);
      rpc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
      cyc(r, rdy, rdir, rpc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
